// File: rtl/pipe_mem_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package pipe_mem_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned BE_W       = DEF_DATA_W / 8;
  localparam int unsigned STREAK_W   = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_I_BUSY = 2'd1,
    ARB_D_BUSY = 2'd2,
    ARB_RESP   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones.
module arb_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Arbitrates fetch (I) and data (D) ports onto one single-ported memory with per-port stalls.
// Define ARB_PERF_CNT_EN to add perf_i_wait/perf_d_wait stall-cycle counters.
module pipe_mem_arbiter
  import pipe_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_stall,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_ready,
  input  logic [DATA_W-1:0]   m_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]         perf_i_wait,
  output logic [31:0]         perf_d_wait
`endif
);

  arb_state_e          state_q,    state_d;
  logic [STREAK_W-1:0] streak_q,   streak_d;
  logic                m_req_q,    m_req_d;
  logic                m_we_q,     m_we_d;
  logic [ADDR_W-1:0]   m_addr_q,   m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q,  m_wdata_d;
  logic [DATA_W/8-1:0] m_be_q,     m_be_d;
  logic                i_rvalid_q, i_rvalid_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]   i_rdata_q,  i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q,  d_rdata_d;
  logic                d_win;

  // D (older instruction) wins unless it has starved a waiting fetch for MAX_D_STREAK grants.
  assign d_win = d_req & (~i_req | (streak_q < STREAK_W'(MAX_D_STREAK)));

  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_be_d     = m_be_q;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (d_win) begin
          state_d   = ARB_D_BUSY;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_be_d    = d_be;
          if (i_req) begin
            if (streak_q != STREAK_W'(MAX_D_STREAK)) begin
              streak_d = streak_q + STREAK_W'(1);
            end
          end else begin
            streak_d = '0;
          end
        end else if (i_req) begin
          state_d   = ARB_I_BUSY;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = i_addr;
          m_wdata_d = '0;
          m_be_d    = '0;
          streak_d  = '0;
        end
      end
      ARB_I_BUSY: begin
        if (m_ready) begin
          state_d    = ARB_RESP;
          m_req_d    = 1'b0;
          i_rdata_d  = m_rdata;
          i_rvalid_d = 1'b1;
        end
      end
      ARB_D_BUSY: begin
        if (m_ready) begin
          state_d    = ARB_RESP;
          m_req_d    = 1'b0;
          d_rdata_d  = m_we_q ? '0 : m_rdata;
          d_rvalid_d = 1'b1;
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      streak_q   <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_be_q     <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_be_q     <= m_be_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_be     = m_be_q;
  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;

  // Stalls are forced low while rst is held so the pipeline is released immediately.
  assign i_stall = i_req & ~i_rvalid_q & ~rst;
  assign d_stall = d_req & ~d_rvalid_q & ~rst;

`ifdef ARB_PERF_CNT_EN
  arb_sat_counter #(.W(32)) u_i_wait (
    .clk    (clk),
    .rst    (rst),
    .en_i   (i_stall),
    .count_o(perf_i_wait)
  );

  arb_sat_counter #(.W(32)) u_d_wait (
    .clk    (clk),
    .rst    (rst),
    .en_i   (d_stall),
    .count_o(perf_d_wait)
  );
`endif

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Self-checking bench for pipe_mem_arbiter: vector table plus arbitration/reset corner sequences.
// Define ARB_PERF_CNT_EN to also check the stall-cycle counters.
module tb_pipe_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_rvalid, i_stall;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_rvalid, d_stall;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        m_req, m_we, m_ready;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_i_wait, perf_d_wait;
`endif

  always #5 clk = ~clk;

  pipe_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ready(m_ready), .m_rdata(m_rdata)
`ifdef ARB_PERF_CNT_EN
    , .perf_i_wait(perf_i_wait), .perf_d_wait(perf_d_wait)
`endif
  );

  typedef struct packed {
    logic        port;   // 0 = I, 1 = D
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  typedef struct {
    req_t        rq;
    int          lat;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          lat   = 1;
  int          mcnt  = 0;
  logic        spur  = 1'b0;
  req_t        iq[$], dq[$], pl[$];
  logic [31:0] exp_i[$], exp_d[$];
  logic        order[$];
  req_t        i_cur, d_cur;
  logic        i_act = 1'b0, d_act = 1'b0;
  int          i_t0, d_t0, i_lat, d_lat;
  int          i_st_n, d_st_n;
  vec_t        tv[6];

  // Memory contents: one known instruction word, everything else an address scramble.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h10) ? 32'h0050_0093 : (a ^ 32'hA5A5_5A5A);
  endfunction

  function automatic req_t mk(input logic p, input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] be);
    return '{port: p, we: we, addr: a, wdata: wd, be: be};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Every memory-side cycle of the finished access must carry the requester's payload.
  task automatic check_payload(input req_t r, input string tag);
    chk({tag, "_m_req_cycles"}, 32'(pl.size()), 32'(lat));
    foreach (pl[k]) begin
      chk({tag, "_m_addr"}, pl[k].addr, r.addr);
      chk({tag, "_m_we"}, 32'(pl[k].we), 32'(r.we));
      if (r.we) begin
        chk({tag, "_m_wdata"}, pl[k].wdata, r.wdata);
        chk({tag, "_m_be"}, 32'(pl[k].be), 32'(r.be));
      end
    end
    pl.delete();
  endtask

  // One clock: sample at negedge, score completions, then drive requesters and memory.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (m_req) pl.push_back('{port: 1'b0, we: m_we, addr: m_addr, wdata: m_wdata, be: m_be});
    if (i_stall) i_st_n++;
    if (d_stall) d_st_n++;
    if (i_rvalid) begin
      order.push_back(1'b0);
      if (!i_act || exp_i.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL i_unexpected_rvalid: got rvalid expected none (cycle %0d)", cyc);
      end else begin
        chk("i_rdata", i_rdata, exp_i.pop_front());
        check_payload(i_cur, "i");
        i_lat = cyc - i_t0;
      end
      i_act = 1'b0;
    end
    if (d_rvalid) begin
      order.push_back(1'b1);
      if (!d_act || exp_d.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL d_unexpected_rvalid: got rvalid expected none (cycle %0d)", cyc);
      end else begin
        chk("d_rdata", d_rdata, exp_d.pop_front());
        check_payload(d_cur, "d");
        d_lat = cyc - d_t0;
      end
      d_act = 1'b0;
    end
    if (!i_act) begin
      if (iq.size() != 0) begin
        i_cur = iq.pop_front();
        i_req = 1'b1; i_addr = i_cur.addr;
        exp_i.push_back(mem_fn(i_cur.addr));
        i_t0 = cyc; i_act = 1'b1;
      end else begin
        i_req = 1'b0;
      end
    end
    if (!d_act) begin
      if (dq.size() != 0) begin
        d_cur = dq.pop_front();
        d_req = 1'b1; d_we = d_cur.we; d_addr = d_cur.addr;
        d_wdata = d_cur.wdata; d_be = d_cur.be;
        exp_d.push_back(d_cur.we ? 32'h0 : mem_fn(d_cur.addr));
        d_t0 = cyc; d_act = 1'b1;
      end else begin
        d_req = 1'b0;
      end
    end
    if (m_req) begin
      mcnt++;
      m_ready = (mcnt >= lat);
      m_rdata = mem_fn(m_addr);
    end else begin
      mcnt = 0;
      m_ready = spur;
      m_rdata = 32'hBAD0_0BAD;
    end
  endtask

  function automatic logic all_idle();
    return (iq.size() == 0) && (dq.size() == 0) && !i_act && !d_act;
  endfunction

  task automatic run_idle(input int max_cyc, input string nm);
    int k;
    k = 0;
    while (!all_idle() && k < max_cyc) begin
      tick();
      k++;
    end
    n_cmp++;
    if (!all_idle()) begin
      n_bad++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected all requests done", nm, k);
      iq.delete(); dq.delete(); i_act = 1'b0; d_act = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    iq.delete(); dq.delete(); exp_i.delete(); exp_d.delete(); pl.delete();
    i_act = 1'b0; d_act = 1'b0; i_req = 1'b0; d_req = 1'b0;
    spur = 1'b0; m_ready = 1'b0; mcnt = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0;
    d_wdata = '0; d_be = '0; m_ready = 1'b0; m_rdata = '0;

    tv[0] = '{rq: mk(1'b0, 1'b0, 32'h10,       32'h0,         4'h0), lat: 1, exp_rdata: 32'h0050_0093, exp_lat: 2};
    tv[1] = '{rq: mk(1'b1, 1'b1, 32'h40,       32'hDEAD_BEEF, 4'h3), lat: 6, exp_rdata: 32'h0,         exp_lat: 7};
    tv[2] = '{rq: mk(1'b1, 1'b0, 32'h200,      32'h1111_2222, 4'hF), lat: 1, exp_rdata: 32'hA5A5_585A, exp_lat: 2};
    tv[3] = '{rq: mk(1'b1, 1'b1, 32'h80,       32'h1234_5678, 4'hF), lat: 1, exp_rdata: 32'h0,         exp_lat: 2};
    tv[4] = '{rq: mk(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,        4'h0), lat: 2, exp_rdata: 32'h5A5A_A5A6, exp_lat: 3};
    tv[5] = '{rq: mk(1'b0, 1'b0, 32'h1234,     32'h0,         4'h0), lat: 3, exp_rdata: 32'hA5A5_486E, exp_lat: 4};

    // Reset state
    do_reset();
    chk("rst_flags", 32'({m_req, m_we, i_rvalid, d_rvalid, i_stall, d_stall}), 32'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_wdata", m_wdata, 32'h0);
    chk("rst_m_be", 32'(m_be), 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);

    // Single isolated accesses from the vector table
    for (int v = 0; v < 6; v++) begin
      lat = tv[v].lat;
      if (tv[v].rq.port) dq.push_back(tv[v].rq);
      else iq.push_back(tv[v].rq);
      run_idle(50, $sformatf("vec%0d", v));
      if (tv[v].rq.port) begin
        chk($sformatf("vec%0d_d_rdata", v), d_rdata, tv[v].exp_rdata);
        chk($sformatf("vec%0d_d_latency", v), 32'(d_lat), 32'(tv[v].exp_lat));
      end else begin
        chk($sformatf("vec%0d_i_rdata", v), i_rdata, tv[v].exp_rdata);
        chk($sformatf("vec%0d_i_latency", v), 32'(i_lat), 32'(tv[v].exp_lat));
      end
      tick();
      chk($sformatf("vec%0d_stall_after", v), 32'({i_stall, d_stall, m_req}), 32'h0);
    end
    chk("d_rdata_held", d_rdata, 32'h5A5A_A5A6);
    chk("i_rdata_held", i_rdata, 32'hA5A5_486E);

    // m_ready outside a busy state must be ignored
    spur = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("spurious_ready", 32'({m_req, i_rvalid, d_rvalid}), 32'h0);
    end
    spur = 1'b0;
    tick();

    // Simultaneous I and D: D first, I waits through the whole D access
    do_reset();
    i_st_n = 0; d_st_n = 0; order.delete(); lat = 1;
    dq.push_back(mk(1'b1, 1'b0, 32'h200, 32'h0, 4'h0));
    iq.push_back(mk(1'b0, 1'b0, 32'h10, 32'h0, 4'h0));
    run_idle(50, "sim");
    chk("sim_order_len", 32'(order.size()), 32'd2);
    if (order.size() == 2) begin
      chk("sim_first_is_d", 32'(order[0]), 32'd1);
      chk("sim_second_is_i", 32'(order[1]), 32'd0);
    end
    chk("sim_i_stall_cycles", 32'(i_st_n), 32'd4);
    chk("sim_d_stall_cycles", 32'(d_st_n), 32'd1);
    tick();
`ifdef ARB_PERF_CNT_EN
    chk("perf_i_wait", perf_i_wait, 32'd5);
    chk("perf_d_wait", perf_d_wait, 32'd2);
`endif

    // Streak limit: D,D,D,D,I repeated while both ports stay busy
    do_reset();
    order.delete(); lat = 1;
    for (int k = 0; k < 12; k++) dq.push_back(mk(1'b1, 1'b0, 32'h1000 + 32'(4 * k), 32'h0, 4'h0));
    for (int k = 0; k < 3; k++) iq.push_back(mk(1'b0, 1'b0, 32'h400 + 32'(4 * k), 32'h0, 4'h0));
    run_idle(400, "streak");
    chk("streak_order_len", 32'(order.size()), 32'd15);
    for (int k = 0; k < 15; k++) begin
      if (k < order.size()) chk($sformatf("streak_grant%0d", k), 32'(order[k]), (k % 5 == 4) ? 32'd0 : 32'd1);
    end
    chk("streak_d_rdata_held", d_rdata, 32'hA5A5_4A76);
    tick();

    // Asynchronous reset in the middle of a long D access
    do_reset();
    lat = 20;
    dq.push_back(mk(1'b1, 1'b0, 32'h300, 32'h0, 4'h0));
    iq.push_back(mk(1'b0, 1'b0, 32'h10, 32'h0, 4'h0));
    for (int k = 0; k < 10 && !m_req; k++) tick();
    tick();
    tick();
    chk("mid_busy_flags", 32'({m_req, i_stall, d_stall}), 32'h7);
    rst = 1'b1;
    #1;
    chk("async_rst_drop", 32'({m_req, i_rvalid, d_rvalid, i_stall, d_stall}), 32'h0);
    do_reset();
    chk("post_rst_m_req", 32'(m_req), 32'h0);
    lat = 1;
    iq.push_back(mk(1'b0, 1'b0, 32'h10, 32'h0, 4'h0));
    run_idle(50, "post_rst");
    chk("post_rst_i_rdata", i_rdata, 32'h0050_0093);
    chk("post_rst_i_latency", 32'(i_lat), 32'd2);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
